// File: rtl/gbc_cpu_pkg.sv
// Shared types for the stack sequencer: stack operation codes and FSM states.
package gbc_cpu_pkg;

  typedef enum logic [1:0] {
    OpLoad = 2'd0,
    OpPush = 2'd1,
    OpPop  = 2'd2,
    OpNop  = 2'd3
  } stack_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrHi,
    StWrLo,
    StRdLo,
    StRdHi,
    StDone
  } seq_state_t;

endpackage

// File: rtl/sp_counter.sv
// 16-bit stack pointer register with load/decrement/increment, wrapping modulo 2^16.
module sp_counter
  import gbc_cpu_pkg::*;
#(
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic        dec,
  input  logic [15:0] load_val,
  output logic [15:0] sp
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (load) begin
      sp <= load_val;
    end else if (dec) begin
      sp <= sp - 16'd1;
    end else if (inc) begin
      sp <= sp + 16'd1;
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Byte-serial 16-bit stack push/pop sequencer over an 8-bit ack-handshake memory port.
// Define STACK_SEQ_BOUNDS_EN to enable the sticky stack-floor overflow flag.
module stack_sequencer
  import gbc_cpu_pkg::*;
#(
  parameter logic [15:0] SP_RESET    = 16'hFFFE,
  parameter logic [15:0] STACK_FLOOR = 16'hC000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  stack_op_t   op_i,
  input  logic [15:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic [15:0] sp_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] addressBus_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        overflow_o
);

  seq_state_t  state;
  logic [7:0]  data_lo_q;
  logic [15:0] sp;
  logic        accept;
  logic        sp_load;
  logic        sp_inc;
  logic        sp_dec;

  assign accept  = (state == StIdle) && start_i;
  assign sp_load = accept && (op_i == OpLoad);
  assign sp_dec  = (accept && (op_i == OpPush)) || ((state == StWrHi) && mem_ack_i);
  assign sp_inc  = ((state == StRdLo) || (state == StRdHi)) && mem_ack_i;

  sp_counter #(
    .SP_RESET(SP_RESET)
  ) u_sp_counter (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (sp_load),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .load_val (data_i),
    .sp       (sp)
  );

  assign sp_o         = sp;
  assign addressBus_o = sp;
  assign busy_o       = (state != StIdle);

  // done_o is registered, so it rises in the cycle after DONE while already back in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= StIdle;
      data_lo_q   <= 8'h00;
      result_o    <= 16'h0000;
      done_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= 8'h00;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_i) begin
            unique case (op_i)
              OpPush: begin
                data_lo_q   <= data_i[7:0];
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_wdata_o <= data_i[15:8];
                state       <= StWrHi;
              end
              OpPop: begin
                mem_req_o <= 1'b1;
                mem_we_o  <= 1'b0;
                state     <= StRdLo;
              end
              OpLoad, OpNop: state <= StDone;
              default:       state <= StDone;
            endcase
          end
        end
        StWrHi: begin
          if (mem_ack_i) begin
            mem_wdata_o <= data_lo_q;
            state       <= StWrLo;
          end
        end
        StWrLo: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= 8'h00;
            state       <= StDone;
          end
        end
        StRdLo: begin
          if (mem_ack_i) begin
            result_o[7:0] <= mem_rdata_i;
            state         <= StRdHi;
          end
        end
        StRdHi: begin
          if (mem_ack_i) begin
            result_o[15:8] <= mem_rdata_i;
            mem_req_o      <= 1'b0;
            state          <= StDone;
          end
        end
        StDone: begin
          done_o <= 1'b1;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef STACK_SEQ_BOUNDS_EN
  logic        ovf_q;
  logic [15:0] sp_minus_one;

  assign sp_minus_one = sp - 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (sp_load) begin
      ovf_q <= 1'b0;
    end else if (sp_dec && ((sp == 16'h0000) || (sp_minus_one < STACK_FLOOR))) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;
`else
  // Floor is only meaningful with bounds checking; keep the parameter referenced.
  logic unused_floor;
  assign unused_floor = ^STACK_FLOOR;
  assign overflow_o   = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed, table-driven bench for stack_sequencer with a byte memory model and ack delay.
module tb_stack_sequencer;
  import gbc_cpu_pkg::*;

`ifdef STACK_SEQ_BOUNDS_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  stack_op_t   op_i = OpNop;
  logic [15:0] data_i = 16'h0000;
  logic        busy_o, done_o, mem_req_o, mem_we_o, overflow_o;
  logic [15:0] result_o, sp_o, addressBus_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic        mem_ack_i = 1'b0;

  stack_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .op_i         (op_i),
    .data_i       (data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .sp_o         (sp_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .addressBus_o (addressBus_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait cycles per byte.
  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  int          ack_delay = 0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (mem_req_o) begin
      mem_rdata_i = mem[addressBus_o];
      mem_ack_i   = (wcnt >= ack_delay);
      if (wcnt >= ack_delay) wcnt = 0;
      else wcnt++;
    end else begin
      mem_ack_i = 1'b0;
      wcnt      = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_i && mem_req_o && mem_we_o && mem_ack_i) begin
      mem[addressBus_o] = mem_wdata_o;
      wr_addr.push_back(addressBus_o);
      wr_data.push_back(mem_wdata_o);
    end
  end

  // Request, address and write data must not move while an ack is pending.
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;
  logic        prev_we;

  always @(posedge clk) begin
    if (rst_i) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && (!mem_req_o || addressBus_o != prev_addr ||
                        mem_wdata_o != prev_wdata || mem_we_o != prev_we)) stab_err++;
      prev_wait  = mem_req_o && !mem_ack_i;
      prev_addr  = addressBus_o;
      prev_wdata = mem_wdata_o;
      prev_we    = mem_we_o;
    end
  end

  typedef struct {
    stack_op_t   op;
    logic [15:0] data;
    int          delay;
    int          lat;
    logic [15:0] sp;
    logic [15:0] result;
    logic        ovf;
    int          nwr;
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs [8];

  task automatic do_op(input stack_op_t op, input logic [15:0] data, input int delay,
                       input bit hold, output int lat);
    bit seen = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    ack_delay = delay;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    data_i  = data;
    lat     = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (!hold) start_i = 1'b0;
      if (done_o) begin
        seen    = 1'b1;
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int ndone;
    bit found;

    vecs[0] = '{OpPush, 16'hBEEF, 0, 4,  16'hFFFC, 16'h0000, 1'b0,  2, 16'hFFFD, 8'hBE, 16'hFFFC, 8'hEF};
    vecs[1] = '{OpPop,  16'h0000, 0, 4,  16'hFFFE, 16'hBEEF, 1'b0,  0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[2] = '{OpNop,  16'h5555, 0, 2,  16'hFFFE, 16'hBEEF, 1'b0,  0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[3] = '{OpLoad, 16'h0001, 0, 2,  16'h0001, 16'hBEEF, 1'b0,  0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[4] = '{OpPush, 16'h1234, 0, 4,  16'hFFFF, 16'hBEEF, OvfEn, 2, 16'h0000, 8'h12, 16'hFFFF, 8'h34};
    vecs[5] = '{OpPop,  16'h0000, 1, 6,  16'h0001, 16'h1234, OvfEn, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[6] = '{OpLoad, 16'hFFFE, 0, 2,  16'hFFFE, 16'h1234, 1'b0,  0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vecs[7] = '{OpPush, 16'hA55A, 3, 10, 16'hFFFC, 16'h1234, 1'b0,  2, 16'hFFFD, 8'hA5, 16'hFFFC, 8'h5A};

    // Reset state
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_sp", sp_o, 16'hFFFE);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_wdata", mem_wdata_o, 8'h00);
    chk("rst_result", result_o, 16'h0000);
    chk("rst_ovf", overflow_o, 1'b0);

    for (int v = 0; v < 8; v++) begin
      do_op(vecs[v].op, vecs[v].data, vecs[v].delay, 1'b0, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_sp", v), sp_o, vecs[v].sp);
      chk($sformatf("v%0d_result", v), result_o, vecs[v].result);
      chk($sformatf("v%0d_ovf", v), overflow_o, vecs[v].ovf);
      chk($sformatf("v%0d_nwr", v), wr_addr.size(), vecs[v].nwr);
      if (vecs[v].nwr == 2 && wr_addr.size() == 2) begin
        chk($sformatf("v%0d_wr0_addr", v), wr_addr[0], vecs[v].a0);
        chk($sformatf("v%0d_wr0_data", v), wr_data[0], vecs[v].d0);
        chk($sformatf("v%0d_wr1_addr", v), wr_addr[1], vecs[v].a1);
        chk($sformatf("v%0d_wr1_data", v), wr_data[1], vecs[v].d1);
      end
    end
    chk("wait_stability", stab_err, 0);

    // start_i held high through busy: one operation only
    do_op(OpPush, 16'h0102, 0, 1'b1, lat);
    chk("hold_latency", lat, 4);
    repeat (3) @(negedge clk);
    chk("hold_sp", sp_o, 16'hFFFA);
    chk("hold_nwr", wr_addr.size(), 2);
    chk("hold_busy", busy_o, 1'b0);

    // Reset while waiting in WR_LO
    wr_addr.delete();
    wr_data.delete();
    ack_delay = 5;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = OpPush;
    data_i  = 16'h7788;
    @(negedge clk);
    start_i = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req_o && mem_we_o && mem_wdata_o == 8'h88) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_wr_lo", found, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_sp", sp_o, 16'hFFFE);
    chk("midrst_req", mem_req_o, 1'b0);
    chk("midrst_we", mem_we_o, 1'b0);
    chk("midrst_wdata", mem_wdata_o, 8'h00);
    chk("midrst_result", result_o, 16'h0000);
    ndone = done_o ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_nwr", wr_addr.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
